frame_responder: RTL and testbench
==================================

FRAME_RESPONDER -- requirements
Module: frame_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, inter-byte receive timeout in clk cycles.
REQ-002 SHALL have parameter REG_DEPTH, default 16, number of 8-bit registers, addressed by addr[3:0].
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rdy  input  1  UART receiver holds a byte on rxdata.
REQ-006 SHALL have port rxdata  input  8  received byte.
REQ-007 SHALL have port rdy_clr  output  1  one-cycle pulse acknowledging the rxdata byte.
REQ-008 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-009 SHALL have port wr_en  output  1  one-cycle pulse loading txdata into the transmitter.
REQ-010 SHALL have port txdata  output  8  byte to transmit.
REQ-011 SHALL have port state  output  5  current FSM state code, for debug.

Function
REQ-012 SHALL accept request frames of 4 bytes: CMD, ADDR, DATA, CHK, where CHK = (CMD+ADDR+DATA) mod 256.
REQ-013 SHALL on each rdy=1 in a receive state latch rxdata and pulse rdy_clr in the same cycle; it SHALL take a byte only when rdy=1 and rdy_clr=0 in that cycle.
REQ-014 SHALL use FSM codes IDLE=0, WAIT_ADDR=1, WAIT_DATA=2, WAIT_CHECKSUM=3, VERIFY_CHECKSUM=4, EXECUTE=5, SEND_STATUS=6, SEND_DATA=7, SEND_CHECKSUM=8, WAIT_TX=9.
REQ-015 SHALL advance IDLE->WAIT_ADDR->WAIT_DATA->WAIT_CHECKSUM->VERIFY_CHECKSUM, one state per byte taken.
REQ-016 SHALL in VERIFY_CHECKSUM (one cycle) compare the 8-bit sum; on mismatch, status = 0x15 (NAK) and response data = 0x00; on match, go to EXECUTE.
REQ-017 SHALL in EXECUTE (one cycle) handle CMD 0x01 as a write of DATA to reg[ADDR[3:0]], with status 0x06 and response data = DATA.
REQ-018 SHALL in EXECUTE handle CMD 0x02 as a read, with status 0x06 and response data = reg[ADDR[3:0]].
REQ-019 SHALL in EXECUTE answer ADDR[7:4]!=0 with status 0x21 and data 0x00 and no register write; any other CMD SHALL get status 0x3F and data 0x00.
REQ-020 SHALL transmit the response STATUS, DATA, RCHK, where RCHK = (STATUS+DATA) mod 256.
REQ-021 SHALL for each response byte pulse wr_en for exactly one cycle, only when tx_busy=0, with txdata valid in that cycle.
REQ-022 SHALL after each wr_en enter WAIT_TX for at least 2 cycles, and leave it only when tx_busy=0; after RCHK it SHALL return to IDLE.
REQ-023 SHALL ignore rdy (no rdy_clr) in VERIFY_CHECKSUM, EXECUTE and the send states; bytes arriving then stay pending for the next frame.
REQ-024 SHALL hold txdata at its last value when wr_en=0.

Reset
REQ-025 SHALL on reset=1 force state=IDLE, rdy_clr=0, wr_en=0, txdata=0x00, the latched frame bytes to 0 and the timeout counter to 0.
REQ-026 SHALL on reset=1 clear all registers to 0x00.
REQ-027 SHALL on reset mid-frame or mid-response abandon the frame or response, with no further wr_en until a new frame completes.

Configuration
REQ-028 SHALL provide macro FRAME_RESPONDER_TIMEOUT_EN.
REQ-029 SHALL when FRAME_RESPONDER_TIMEOUT_EN is defined count cycles in WAIT_ADDR, WAIT_DATA and WAIT_CHECKSUM, clear the count on each byte taken, and on reaching TIMEOUT_CYCLES return to IDLE with no response and no register change.
REQ-030 SHALL when FRAME_RESPONDER_TIMEOUT_EN is undefined have no timeout counter, and wait indefinitely in the receive states.

Structure
REQ-031 SHALL take from shared package frame_pkg the state codes, CMD codes (0x01, 0x02) and status codes (0x06, 0x15, 0x21, 0x3F).
REQ-032 SHALL place the register array in sub-module resp_regfile, with one synchronous write port, one combinational read port and synchronous reset.

Verification
REQ-033 SHALL verify: frame 01 03 61 65 -> response 06 61 67, reg[3]=0x61.
REQ-034 SHALL verify: after REQ-033, frame 02 03 00 05 -> response 06 61 67.
REQ-035 SHALL verify: frame 01 04 55 00 (bad CHK) -> response 15 00 15, reg[4] unchanged at 0x00.
REQ-036 SHALL verify: frame 07 00 00 07 -> response 3F 00 3F; frame 02 10 00 12 -> response 21 00 21.
REQ-037 SHALL verify: tx_busy=1 held for 100 cycles after each wr_en -> each next wr_en occurs only after tx_busy falls, with exactly 3 wr_en pulses per frame.
REQ-038 SHALL verify: reset asserted after bytes 01 03 -> state=0 the next cycle; then frame 02 03 00 05 -> response 06 00 06; with TIMEOUT_EN and TIMEOUT_CYCLES=20, a 25-cycle gap after 01 returns state to 0 with no response.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the frame responder: FSM state codes, request
// command codes, response status codes and the 8-bit checksum helper.
package frame_pkg;

    // FSM state codes; the numeric values are visible on the debug port.
    typedef enum logic [4:0] {
        ST_IDLE            = 5'd0,
        ST_WAIT_ADDR       = 5'd1,
        ST_WAIT_DATA       = 5'd2,
        ST_WAIT_CHECKSUM   = 5'd3,
        ST_VERIFY_CHECKSUM = 5'd4,
        ST_EXECUTE         = 5'd5,
        ST_SEND_STATUS     = 5'd6,
        ST_SEND_DATA       = 5'd7,
        ST_SEND_CHECKSUM   = 5'd8,
        ST_WAIT_TX         = 5'd9
    } state_e;

    // Request command codes.
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    // Response status codes.
    localparam logic [7:0] STAT_ACK      = 8'h06;
    localparam logic [7:0] STAT_NAK      = 8'h15;
    localparam logic [7:0] STAT_BAD_ADDR = 8'h21;
    localparam logic [7:0] STAT_BAD_CMD  = 8'h3F;

    // Register file address width (addr[3:0]).
    localparam int unsigned REG_AW = 4;

    // Modulo-256 sum used for both request and response checksums.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/resp_regfile.sv
// Register array for the frame responder: one synchronous write port,
// one combinational read port, synchronous active-high reset to 0x00.
// Out-of-range addresses (only possible when DEPTH < 2**AW) are ignored on
// write and read back as 0x00.
module resp_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] regs_q [DEPTH];

    // Register storage: clear on reset, otherwise write on we_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '{default: 8'h00};
        end else if (we_i && (int'(waddr_i) < DEPTH)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read with out-of-range guard.
    always_comb begin
        rdata_o = 8'h00;
        if (int'(raddr_i) < DEPTH) begin
            rdata_o = regs_q[raddr_i];
        end else begin
            rdata_o = 8'h00;
        end
    end

endmodule

// File: rtl/frame_responder.sv
// Frame responder: receives 4-byte request frames (CMD, ADDR, DATA, CHK)
// from a UART receiver, executes register reads/writes and answers with a
// 3-byte response (STATUS, DATA, RCHK) through a UART transmitter.
// Optional build macro FRAME_RESPONDER_TIMEOUT_EN enables an inter-byte
// receive timeout of TIMEOUT_CYCLES clocks; without it the receive states
// wait indefinitely.
module frame_responder
    import frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int REG_DEPTH      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic [7:0] rxdata,
    output logic       rdy_clr,
    input  logic       tx_busy,
    output logic       wr_en,
    output logic [7:0] txdata,
    output logic [4:0] state
);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;        // send state to resume after WAIT_TX
    logic       wait_q, wait_d;      // first WAIT_TX cycle already spent
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] status_q, status_d;
    logic [7:0] rsp_q, rsp_d;
    logic       rdy_clr_q, rdy_clr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] txdata_q, txdata_d;

    logic       take_s;              // a new byte is accepted this cycle
    logic       timeout_s;           // inter-byte timeout expires this cycle
    logic       we_s;
    logic [7:0] rdata_s;

    assign take_s  = rdy && !rdy_clr_q;
    assign rdy_clr = rdy_clr_q;
    assign wr_en   = wr_en_q;
    assign txdata  = txdata_q;
    assign state   = state_q;

    resp_regfile #(
        .DEPTH (REG_DEPTH),
        .AW    (REG_AW)
    ) u_regfile (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (we_s),
        .waddr_i (addr_q[REG_AW-1:0]),
        .wdata_i (data_q),
        .raddr_i (addr_q[REG_AW-1:0]),
        .rdata_o (rdata_s)
    );

`ifdef FRAME_RESPONDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            rx_wait_s;

    // Inter-byte timeout: count idle cycles in the mid-frame receive states.
    always_comb begin
        rx_wait_s = (state_q == ST_WAIT_ADDR) || (state_q == ST_WAIT_DATA) ||
                    (state_q == ST_WAIT_CHECKSUM);
        to_cnt_d  = {TO_W{1'b0}};
        if (rx_wait_s && !take_s) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
        timeout_s = rx_wait_s && !take_s && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= {TO_W{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // No timeout: receive states wait forever (never true for legal settings).
    assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and output logic for the receive/execute/transmit FSM.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        wait_d    = wait_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        chk_d     = chk_q;
        status_d  = status_q;
        rsp_d     = rsp_q;
        rdy_clr_d = 1'b0;
        wr_en_d   = 1'b0;
        txdata_d  = txdata_q;
        we_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    cmd_d     = rxdata;
                    rdy_clr_d = 1'b1;
                    state_d   = ST_WAIT_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ADDR: begin
                if (take_s) begin
                    addr_d    = rxdata;
                    rdy_clr_d = 1'b1;
                    state_d   = ST_WAIT_DATA;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_ADDR;
                end
            end
            ST_WAIT_DATA: begin
                if (take_s) begin
                    data_d    = rxdata;
                    rdy_clr_d = 1'b1;
                    state_d   = ST_WAIT_CHECKSUM;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_CHECKSUM: begin
                if (take_s) begin
                    chk_d     = rxdata;
                    rdy_clr_d = 1'b1;
                    state_d   = ST_VERIFY_CHECKSUM;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_CHECKSUM;
                end
            end
            ST_VERIFY_CHECKSUM: begin
                if (sum8(sum8(cmd_q, addr_q), data_q) == chk_q) begin
                    state_d = ST_EXECUTE;
                end else begin
                    status_d = STAT_NAK;
                    rsp_d    = 8'h00;
                    state_d  = ST_SEND_STATUS;
                end
            end
            ST_EXECUTE: begin
                // Unknown commands win over a bad address.
                if ((cmd_q != CMD_WRITE) && (cmd_q != CMD_READ)) begin
                    status_d = STAT_BAD_CMD;
                    rsp_d    = 8'h00;
                end else if (addr_q[7:4] != 4'h0) begin
                    status_d = STAT_BAD_ADDR;
                    rsp_d    = 8'h00;
                end else if (cmd_q == CMD_WRITE) begin
                    we_s     = 1'b1;
                    status_d = STAT_ACK;
                    rsp_d    = data_q;
                end else begin
                    status_d = STAT_ACK;
                    rsp_d    = rdata_s;
                end
                state_d = ST_SEND_STATUS;
            end
            ST_SEND_STATUS: begin
                if (!tx_busy) begin
                    wr_en_d  = 1'b1;
                    txdata_d = status_q;
                    ret_d    = ST_SEND_DATA;
                    wait_d   = 1'b0;
                    state_d  = ST_WAIT_TX;
                end else begin
                    state_d = ST_SEND_STATUS;
                end
            end
            ST_SEND_DATA: begin
                if (!tx_busy) begin
                    wr_en_d  = 1'b1;
                    txdata_d = rsp_q;
                    ret_d    = ST_SEND_CHECKSUM;
                    wait_d   = 1'b0;
                    state_d  = ST_WAIT_TX;
                end else begin
                    state_d = ST_SEND_DATA;
                end
            end
            ST_SEND_CHECKSUM: begin
                if (!tx_busy) begin
                    wr_en_d  = 1'b1;
                    txdata_d = sum8(status_q, rsp_q);
                    ret_d    = ST_IDLE;
                    wait_d   = 1'b0;
                    state_d  = ST_WAIT_TX;
                end else begin
                    state_d = ST_SEND_CHECKSUM;
                end
            end
            ST_WAIT_TX: begin
                // First cycle gives the transmitter time to raise tx_busy.
                if (!wait_q) begin
                    wait_d  = 1'b1;
                    state_d = ST_WAIT_TX;
                end else if (!tx_busy) begin
                    state_d = ret_q;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched frame bytes and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            wait_q    <= 1'b0;
            cmd_q     <= 8'h00;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            chk_q     <= 8'h00;
            status_q  <= 8'h00;
            rsp_q     <= 8'h00;
            rdy_clr_q <= 1'b0;
            wr_en_q   <= 1'b0;
            txdata_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            wait_q    <= wait_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            status_q  <= status_d;
            rsp_q     <= rsp_d;
            rdy_clr_q <= rdy_clr_d;
            wr_en_q   <= wr_en_d;
            txdata_q  <= txdata_d;
        end
    end

endmodule

// File: tb/tb_frame_responder.sv
// Scoreboard bench for frame_responder: a driver plays a UART receiver and
// pushes expected response bytes; a monitor plays a UART transmitter and
// compares every wr_en byte against the queue.
module tb_frame_responder;

`ifdef FRAME_RESPONDER_TIMEOUT_EN
    localparam int TO_CYC = 20;
`else
    localparam int TO_CYC = 50000;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rdy     = 1'b0;
    logic [7:0] rxdata  = 8'h00;
    logic       tx_busy = 1'b0;
    logic       rdy_clr;
    logic       wr_en;
    logic [7:0] txdata;
    logic [4:0] state;

    int         tests_run = 0;
    int         fails     = 0;
    int         busy_len  = 0;
    int         wr_cnt    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mregs[16];
    logic [7:0] last_tx = 8'h00;

    frame_responder #(
        .TIMEOUT_CYCLES (TO_CYC),
        .REG_DEPTH      (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rdy     (rdy),
        .rxdata  (rxdata),
        .rdy_clr (rdy_clr),
        .tx_busy (tx_busy),
        .wr_en   (wr_en),
        .txdata  (txdata),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: response {status, data} from the frame rules.
    function automatic logic [15:0] model(input logic [7:0] c, input logic [7:0] a,
                                          input logic [7:0] d, input logic [7:0] k);
        logic [7:0] s;
        logic [7:0] sum;
        sum = c + a + d;
        if (sum != k)                         return {8'h15, 8'h00};
        if ((c != 8'h01) && (c != 8'h02))     return {8'h3F, 8'h00};
        if (a > 8'd15)                        return {8'h21, 8'h00};
        if (c == 8'h01) begin
            mregs[a[3:0]] = d;
            return {8'h06, d};
        end
        s = 8'h06;
        return {s, mregs[a[3:0]]};
    endfunction

    task automatic push_rsp(input logic [7:0] s, input logic [7:0] r);
        logic [7:0] rc;
        rc = s + r;
        exp_q.push_back(s);
        exp_q.push_back(r);
        exp_q.push_back(rc);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rdy    = 1'b1;
        rxdata = b;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy_clr && n < 5000);
        if (!rdy_clr) begin
            tests_run++;
            fails++;
            $display("FAIL byte_ack: byte %02h not acknowledged within %0d cycles", b, n);
        end
        rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    // Directed frame: the model is kept in step, expected bytes are constants.
    task automatic directed(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] k, input logic [7:0] s, input logic [7:0] r);
        logic [15:0] unused_m;
        unused_m = model(c, a, d, k);
        push_rsp(s, r);
        send_frame(c, a, d, k);
    endtask

    task automatic random_frame();
        logic [7:0] c, a, d, k;
        logic [15:0] m;
        case ($urandom_range(0, 2))
            0:       c = 8'h01;
            1:       c = 8'h02;
            default: c = 8'($urandom);
        endcase
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        d = 8'($urandom);
        k = c + a + d;
        if ($urandom_range(0, 5) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
        m = model(c, a, d, k);
        push_rsp(m[15:8], m[7:0]);
        send_frame(c, a, d, k);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || state != 5'd0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            tests_run++;
            fails++;
            $display("FAIL %s: response not complete, %0d bytes outstanding, state %0d",
                     name, exp_q.size(), state);
        end
        repeat (3) @(negedge clk);
    endtask

    // Transmitter model: hold tx_busy for busy_len cycles after each wr_en.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_en && !reset && busy_len > 0) begin
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: compare every transmitted byte and txdata hold behaviour.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_tx = 8'h00;
            end else if (wr_en) begin
                wr_cnt++;
                check("wr_en_while_busy", {31'd0, tx_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_wr_en: txdata %02h with no response expected", txdata);
                    last_tx = txdata;
                end else begin
                    exp_b = exp_q.pop_front();
                    check("response_byte", {24'd0, txdata}, {24'd0, exp_b});
                    last_tx = exp_b;
                end
            end else begin
                check("txdata_hold", {24'd0, txdata}, {24'd0, last_tx});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        foreach (mregs[i]) mregs[i] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_state", {27'd0, state}, 32'd0);
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_rdy_clr", {31'd0, rdy_clr}, 32'd0);
        check("reset_txdata", {24'd0, txdata}, 32'd0);
        reset = 1'b0;

        // Directed frames.
        busy_len = 3;
        wr_cnt = 0;
        directed(8'h01, 8'h03, 8'h61, 8'h65, 8'h06, 8'h61);
        drain("write_r3");
        check("wr_pulses_write", wr_cnt, 32'd3);
        directed(8'h02, 8'h03, 8'h00, 8'h05, 8'h06, 8'h61);
        directed(8'h01, 8'h04, 8'h55, 8'h00, 8'h15, 8'h00);
        directed(8'h02, 8'h04, 8'h00, 8'h06, 8'h06, 8'h00);
        directed(8'h07, 8'h00, 8'h00, 8'h07, 8'h3F, 8'h00);
        directed(8'h02, 8'h10, 8'h00, 8'h12, 8'h21, 8'h00);
        drain("directed");

        // Slow transmitter: 100 busy cycles after each wr_en.
        busy_len = 100;
        wr_cnt = 0;
        directed(8'h01, 8'h05, 8'hAA, 8'hB0, 8'h06, 8'hAA);
        drain("slow_write");
        check("wr_pulses_slow_write", wr_cnt, 32'd3);
        wr_cnt = 0;
        directed(8'h02, 8'h05, 8'h00, 8'h07, 8'h06, 8'hAA);
        drain("slow_read");
        check("wr_pulses_slow_read", wr_cnt, 32'd3);

        // Reset mid-response: response abandoned, no further wr_en.
        wr_cnt = 0;
        push_rsp(8'h06, 8'h00);
        send_frame(8'h02, 8'h06, 8'h00, 8'h08);
        n = 0;
        while (wr_cnt < 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("first_wr_before_reset", wr_cnt, 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        foreach (mregs[i]) mregs[i] = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("no_wr_after_reset", wr_cnt, 32'd1);

        // Reset mid-frame after 01 03, then read reg[3] (cleared by reset).
        busy_len = 2;
        send_byte(8'h01);
        send_byte(8'h03);
        @(negedge clk);
        reset = 1'b1;
        foreach (mregs[i]) mregs[i] = 8'h00;
        @(negedge clk);
        check("state_after_reset", {27'd0, state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        directed(8'h02, 8'h03, 8'h00, 8'h05, 8'h06, 8'h00);
        drain("read_after_reset");

        // Randomized back-to-back frames against the reference model.
        for (int i = 0; i < 40; i++) begin
            busy_len = $urandom_range(0, 4);
            random_frame();
        end
        drain("random");
        for (int i = 0; i < 16; i++) begin
            logic [15:0] m;
            logic [7:0]  a, k;
            a = 8'(i);
            k = 8'h02 + a;
            m = model(8'h02, a, 8'h00, k);
            push_rsp(m[15:8], m[7:0]);
            send_frame(8'h02, a, 8'h00, k);
        end
        drain("readback");

`ifdef FRAME_RESPONDER_TIMEOUT_EN
        // Inter-byte timeout after a lone CMD byte.
        wr_cnt = 0;
        send_byte(8'h01);
        repeat (25) @(negedge clk);
        check("timeout_state", {27'd0, state}, 32'd0);
        repeat (20) @(negedge clk);
        check("timeout_no_rsp", wr_cnt, 32'd0);
        directed(8'h02, 8'h00, 8'h00, 8'h02, 8'h06, mregs[0]);
        drain("after_timeout");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
